// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//
// Purpose:
//   WIDTH-bit ripple-carry adder. It is built from a chain of identical 1-bit
//   full-adder cells. The combinational result {carry, sum} is available with
//   zero latency for use as a datapath primitive. An optional registered copy
//   (sum_r, carry_r, valid_r) serves pipelined users that want the result one
//   cycle later.
//
// Parameters:
//   WIDTH   operand width in bits, legal range 1..64 (default 1 = classic cell)
//
// Ports:
//   clk      in   1      rising-edge clock, used by the registered path only
//   rst_n    in   1      asynchronous active-low reset of the registered path
//   a_in     in   WIDTH  operand A, unsigned
//   b_in     in   WIDTH  operand B, unsigned
//   c_in     in   1      carry into bit 0
//   en       in   1      load enable for the registered result
//   sum      out  WIDTH  combinational sum
//   carry    out  1      combinational carry out of the MSB
//   sum_r    out  WIDTH  registered sum
//   carry_r  out  1      registered carry out
//   valid_r  out  1      high for one cycle after each cycle with en=1
//
// Handshake: valid_r is a pure "result present" strobe. There is no ready
// input and no back-pressure. A capture on a cycle with en=1 is always taken.
// The matching valid_r pulse lasts exactly the following cycle unless en stays
// high.
// -----------------------------------------------------------------------------
module full_adder #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
   input  logic             en,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic [WIDTH-1:0] sum_r,
   output logic             carry_r,
   output logic             valid_r
);

   // Carry chain: c[0] is the external carry-in, and c[WIDTH] is the carry-out.
   logic [WIDTH:0] c;

   assign c[0] = c_in;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_cell
         logic p;  // propagate: this bit passes an incoming carry through
         assign p        = a_in[i] ^ b_in[i];
         assign sum[i]   = p ^ c[i];
         assign c[i+1]   = (a_in[i] & b_in[i]) | (c[i] & p);
      end
   endgenerate

   assign carry = c[WIDTH];

   // Registered copy. When en is low, the data registers keep their value and
   // only the strobe drops. Reset clears everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_r   <= '0;
         carry_r <= 1'b0;
         valid_r <= 1'b0;
      end else if (en) begin
         sum_r   <= sum;
         carry_r <= carry;
         valid_r <= 1'b1;
      end else begin
         valid_r <= 1'b0;
      end
   end

endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
//
// Bench for full_adder. It uses two instances: WIDTH=1 (the cell) and WIDTH=8
// (the ripple chain). Both share the clock and reset. Expected values come
// from constant tables and from a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_full_adder;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic [0:0] a1, b1, sum1, sum_r1;
   logic       c1, en1, carry1, carry_r1, valid_r1;

   logic [7:0] a8, b8, sum8, sum_r8;
   logic       c8, en8, carry8, carry_r8, valid_r8;

   full_adder #(.WIDTH(1)) u_fa1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .a_in    (a1),
      .b_in    (b1),
      .c_in    (c1),
      .en      (en1),
      .sum     (sum1),
      .carry   (carry1),
      .sum_r   (sum_r1),
      .carry_r (carry_r1),
      .valid_r (valid_r1)
   );

   full_adder #(.WIDTH(8)) u_fa8 (
      .clk     (clk),
      .rst_n   (rst_n),
      .a_in    (a8),
      .b_in    (b8),
      .c_in    (c8),
      .en      (en8),
      .sum     (sum8),
      .carry   (carry8),
      .sum_r   (sum_r8),
      .carry_r (carry_r8),
      .valid_r (valid_r8)
   );

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Vector record: inputs plus expected {carry, sum}.
   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic       exp_carry;
      logic [7:0] exp_sum;
   } vec_t;

   vec_t tt1 [8];  // 1-bit truth table, indexed by {a,b,c}
   vec_t bnd8[4];  // 8-bit boundary vectors

   // Expected registered value for u_fa8: {carry, sum} of the last capture.
   logic [8:0] exp_q[$];

   // ---------------- driver helpers ----------------
   task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic e);
      a8 = a; b8 = b; c8 = c; en8 = e;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [8:0] model;
      logic [8:0] held;
      logic [7:0] ra, rb;
      logic       rc, re;

      // Truth table from the specification: abc -> carry,sum.
      tt1[0] = '{8'd0, 8'd0, 1'b0, 1'b0, 8'd0};
      tt1[1] = '{8'd0, 8'd0, 1'b1, 1'b0, 8'd1};
      tt1[2] = '{8'd0, 8'd1, 1'b0, 1'b0, 8'd1};
      tt1[3] = '{8'd0, 8'd1, 1'b1, 1'b1, 8'd0};
      tt1[4] = '{8'd1, 8'd0, 1'b0, 1'b0, 8'd1};
      tt1[5] = '{8'd1, 8'd0, 1'b1, 1'b1, 8'd0};
      tt1[6] = '{8'd1, 8'd1, 1'b0, 1'b1, 8'd0};
      tt1[7] = '{8'd1, 8'd1, 1'b1, 1'b1, 8'd1};

      bnd8[0] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h00};
      bnd8[1] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF};
      bnd8[2] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
      bnd8[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80};

      a1 = '0; b1 = '0; c1 = 1'b0; en1 = 1'b0;
      drive8(8'h00, 8'h00, 1'b0, 1'b0);

      // Reset state of the registered outputs.
      #1;
      chk("rst_state_w1", {sum_r1, carry_r1, valid_r1}, 3'b000);
      chk("rst_state_w8", {sum_r8, carry_r8, valid_r8}, 10'd0);

      // Exhaustive 1-bit sweep. c toggles every 5 ns, b every 10 ns, a every
      // 20 ns. Run two full periods and check 1 ns after each change.
      for (int t = 0; t < 16; t++) begin
         a1 = tt1[t % 8].a[0:0];
         b1 = tt1[t % 8].b[0:0];
         c1 = tt1[t % 8].c;
         #1;
         chk($sformatf("tt1_%0d", t % 8), {carry1, sum1},
             {tt1[t % 8].exp_carry, tt1[t % 8].exp_sum[0]});
         #4;
      end

      // Reset held with en=1 and 1,1,1 applied: registers stay 0, and the
      // combinational path keeps working.
      a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; en1 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("rst_hold_reg", {sum_r1, carry_r1, valid_r1}, 3'b000);
         chk("rst_hold_comb", {carry1, sum1}, 2'b11);
      end

      // Release, then capture a=1,b=0,c=1 -> sum=0, carry=1.
      @(negedge clk);
      rst_n = 1'b1;
      a1 = 1'b1; b1 = 1'b0; c1 = 1'b1; en1 = 1'b1;
      @(posedge clk); #1;
      chk("cap_reg", {sum_r1, carry_r1, valid_r1}, 3'b011);

      // en=0 and a=0: the data holds and valid drops.
      @(negedge clk);
      en1 = 1'b0; a1 = 1'b0;
      @(posedge clk); #1;
      chk("hold_reg", {sum_r1, carry_r1, valid_r1}, 3'b010);
      chk("hold_comb", {carry1, sum1}, 2'b01);

      // Capture 1+1+1, then pulse reset between edges.
      @(negedge clk);
      a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; en1 = 1'b1;
      @(posedge clk); #1;
      chk("cap111_reg", {sum_r1, carry_r1, valid_r1}, 3'b111);
      en1 = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_clear", {sum_r1, carry_r1, valid_r1}, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_en0", {sum_r1, carry_r1, valid_r1}, 3'b000);

      // 8-bit boundaries: combinational result, then a registered capture.
      for (int v = 0; v < 4; v++) begin
         @(negedge clk);
         drive8(bnd8[v].a, bnd8[v].b, bnd8[v].c, 1'b1);
         #1;
         chk($sformatf("bnd8_comb_%0d", v), {carry8, sum8}, {bnd8[v].exp_carry, bnd8[v].exp_sum});
         @(posedge clk); #1;
         chk($sformatf("bnd8_reg_%0d", v), {carry_r8, sum_r8, valid_r8},
             {bnd8[v].exp_carry, bnd8[v].exp_sum, 1'b1});
      end

      // Clean start for the random run.
      @(negedge clk);
      en8 = 1'b0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      exp_q.delete();
      exp_q.push_back(9'd0);

      // Random 8-bit run against an arithmetic model.
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rc = 1'($urandom_range(0, 1));
         re = 1'($urandom_range(0, 1));
         drive8(ra, rb, rc, re);
         model = 9'(ra) + 9'(rb) + 9'(rc);
         #1;
         chk("rand_comb", {carry8, sum8}, model);
         if (re) begin
            void'(exp_q.pop_front());
            exp_q.push_back(model);
         end
         held = exp_q[0];
         @(posedge clk); #1;
         chk("rand_reg", {carry_r8, sum_r8, valid_r8}, {held, re});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
